// File: rtl/conv_weight_loader_if.sv
// Bundles the load-control, ROM read and weight-output signals of conv_weight_loader.
// master = the loader itself, slave = the surrounding system (control source + ROM).
interface conv_weight_loader_if #(
   parameter int DATA_WIDTH = 16,
   parameter int F          = 64,
   parameter int K          = 4,
   parameter int ADDR_W     = 3
);
   logic                         start;
   logic [ADDR_W-1:0]            base_addr;
   logic                         rom_en;
   logic [ADDR_W-1:0]            rom_addr;
   logic [DATA_WIDTH*F-1:0]      rom_dout;
   logic                         busy;
   logic                         read_flag;
   logic [DATA_WIDTH*F*K-1:0]    weights;
   logic [1:0]                   dbg_state;

   modport master (
      input  start, base_addr, rom_dout,
      output rom_en, rom_addr, busy, read_flag, weights, dbg_state
   );

   modport slave (
      output start, base_addr, rom_dout,
      input  rom_en, rom_addr, busy, read_flag, weights, dbg_state
   );
endinterface

// File: rtl/conv_weight_loader.sv
// Streams K ROM words (one per kernel tap) into a flat weight register for the 1D conv array,
// with start-triggered reload, per-load base address and a ROM_LATENCY-deep capture pipeline.
module conv_weight_loader #(
   parameter int DATA_WIDTH  = 16,
   parameter int F           = 64,
   parameter int K           = 4,
   parameter int ADDR_W      = 3,
   parameter int ROM_LATENCY = 1,
   parameter int AUTO_START  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   conv_weight_loader_if.master bus
);
   localparam int WW = DATA_WIDTH * F;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

   state_t                 state, state_nxt;
   logic                   post_reset;
   logic                   accept;
   logic                   last_issue;
   logic                   cap_fire;
   logic                   cap_last;
   logic [CW-1:0]          iss_cnt;
   logic [CW-1:0]          cap_idx;
   logic [ROM_LATENCY-1:0] vld;
   logic [ADDR_W-1:0]      addr_q;
   logic [WW*K-1:0]        w_q;

   // Handshake: a load is accepted on any edge where start=1 and the loader is in IDLE or DONE;
   // busy is high from the accept edge until the last-tap capture edge, where read_flag rises
   // and stays high until the next accept. start while busy is dropped, never queued.
   assign accept = ((state == IDLE) && (bus.start || ((AUTO_START != 0) && post_reset))) ||
                   ((state == DONE) && bus.start);
   assign last_issue = (iss_cnt == CW'(K - 1));
   assign cap_fire   = vld[ROM_LATENCY-1];
   assign cap_last   = cap_fire && (cap_idx == CW'(K - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (accept)     state_nxt = FETCH;
         FETCH:      if (last_issue) state_nxt = DRAIN;
         DRAIN:      if (cap_last)   state_nxt = DONE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.rom_en    = 1'b0;
      bus.busy      = 1'b0;
      bus.read_flag = 1'b0;
      bus.dbg_state = state;
      case (state)
         FETCH: begin
            bus.rom_en = 1'b1;
            bus.busy   = 1'b1;
         end
         DRAIN:   bus.busy      = 1'b1;
         DONE:    bus.read_flag = 1'b1;
         default: ;
      endcase
   end

   // High only on the first edge after reset releases; that edge may auto-start a load.
   always_ff @(posedge clk) post_reset <= reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= '0;
         iss_cnt <= '0;
         cap_idx <= '0;
         vld     <= '0;
         w_q     <= '0;
      end else begin
         // Each FETCH cycle the ROM samples one address; its data lands ROM_LATENCY edges later.
         vld <= ROM_LATENCY'({vld, (state == FETCH)});
         if (accept) begin
            addr_q  <= bus.base_addr;
            iss_cnt <= '0;
            cap_idx <= '0;
         end else if ((state == FETCH) && !last_issue) begin
            addr_q  <= addr_q + 1'b1;
            iss_cnt <= iss_cnt + 1'b1;
         end
         if (cap_fire) begin
            for (int k = 0; k < K; k++) begin
               if (cap_idx == CW'(k)) w_q[(K-1-k)*WW +: WW] <= bus.rom_dout;
            end
            cap_idx <= cap_idx + 1'b1;
         end
      end
   end

   assign bus.rom_addr = addr_q;
   assign bus.weights  = w_q;
endmodule

// File: tb/tb_conv_weight_loader.sv
// Directed bench for conv_weight_loader: three instances cover ROM latencies 1/3/2 and both
// AUTO_START settings; expected ROM addresses and tap words are queued at each load request.
module tb_conv_weight_loader;
   localparam int DW = 16;
   localparam int FF = 64;
   localparam int KK = 4;
   localparam int AW = 3;
   localparam int WW = DW * FF;
   localparam int TW = WW * KK;

   logic          clk;
   logic          reset;
   logic          start0, start1, start2;
   logic [AW-1:0] base_addr;

   int total = 0;
   int bad   = 0;
   int sel   = 0;

   logic [AW-1:0] addr_exp[$];
   logic [WW-1:0] exp_q[$];

   logic          obs_en, obs_busy, obs_rf;
   logic [AW-1:0] obs_addr;
   logic [1:0]    obs_st;
   logic [TW-1:0] obs_w;

   logic [WW-1:0] junk;
   logic [WW-1:0] p0, p1a, p1b, p1c, p2a, p2b;

   conv_weight_loader_if #(.DATA_WIDTH(DW), .F(FF), .K(KK), .ADDR_W(AW)) b0 ();
   conv_weight_loader_if #(.DATA_WIDTH(DW), .F(FF), .K(KK), .ADDR_W(AW)) b1 ();
   conv_weight_loader_if #(.DATA_WIDTH(DW), .F(FF), .K(KK), .ADDR_W(AW)) b2 ();

   conv_weight_loader #(.DATA_WIDTH(DW), .F(FF), .K(KK), .ADDR_W(AW),
                        .ROM_LATENCY(1), .AUTO_START(1))
      u0 (.clk(clk), .reset(reset), .bus(b0));
   conv_weight_loader #(.DATA_WIDTH(DW), .F(FF), .K(KK), .ADDR_W(AW),
                        .ROM_LATENCY(3), .AUTO_START(0))
      u1 (.clk(clk), .reset(reset), .bus(b1));
   conv_weight_loader #(.DATA_WIDTH(DW), .F(FF), .K(KK), .ADDR_W(AW),
                        .ROM_LATENCY(2), .AUTO_START(0))
      u2 (.clk(clk), .reset(reset), .bus(b2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [WW-1:0] word(input logic [AW-1:0] a);
      logic [DW-1:0] v;
      v = 16'h0A00 + {13'd0, a};
      return {FF{v}};
   endfunction

   assign b0.start = start0;
   assign b1.start = start1;
   assign b2.start = start2;
   assign b0.base_addr = base_addr;
   assign b1.base_addr = base_addr;
   assign b2.base_addr = base_addr;
   assign junk = {FF{16'hDEAD}};

   // ROM models: registered read, depth equal to each instance's ROM_LATENCY.
   always @(posedge clk) p0 <= b0.rom_en ? word(b0.rom_addr) : junk;
   always @(posedge clk) begin
      p1a <= b1.rom_en ? word(b1.rom_addr) : junk;
      p1b <= p1a;
      p1c <= p1b;
   end
   always @(posedge clk) begin
      p2a <= b2.rom_en ? word(b2.rom_addr) : junk;
      p2b <= p2a;
   end
   assign b0.rom_dout = p0;
   assign b1.rom_dout = p1c;
   assign b2.rom_dout = p2b;

   always_comb begin
      obs_en = b2.rom_en; obs_addr = b2.rom_addr; obs_busy = b2.busy;
      obs_rf = b2.read_flag; obs_st = b2.dbg_state; obs_w = b2.weights;
      case (sel)
         0: begin
            obs_en = b0.rom_en; obs_addr = b0.rom_addr; obs_busy = b0.busy;
            obs_rf = b0.read_flag; obs_st = b0.dbg_state; obs_w = b0.weights;
         end
         1: begin
            obs_en = b1.rom_en; obs_addr = b1.rom_addr; obs_busy = b1.busy;
            obs_rf = b1.read_flag; obs_st = b1.dbg_state; obs_w = b1.weights;
         end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic chk_slice(input string tag, input logic [WW-1:0] o, input logic [WW-1:0] e);
      int lane;
      total++;
      assert (o === e) else begin
         bad++;
         lane = 0;
         for (int i = FF - 1; i >= 0; i--) if (o[i*DW +: DW] !== e[i*DW +: DW]) lane = i;
         $error("FAIL %s lane=%0d observed=%h expected=%h", tag, lane,
                o[lane*DW +: DW], e[lane*DW +: DW]);
      end
   endtask

   // One clock edge; every ROM read issued by the selected instance is checked against the queue.
   task automatic tick();
      @(posedge clk);
      #1;
      if (obs_en === 1'b1) begin
         chk("rom_read_expected", addr_exp.size() != 0, 1);
         if (addr_exp.size() != 0) chk("rom_addr", obs_addr, addr_exp.pop_front());
      end
      chk("busy_and_flag", obs_busy & obs_rf, 0);
   endtask

   task automatic expect_load(input logic [AW-1:0] base);
      logic [AW-1:0] a;
      for (int k = 0; k < KK; k++) begin
         a = base + AW'(k);
         addr_exp.push_back(a);
         exp_q.push_back(word(a));
      end
   endtask

   // The next edge must be the accept edge; read_flag must rise exactly lat edges later.
   task automatic run_load(input string tag, input int lat, input bit drop);
      int n;
      int busy_n;
      tick();
      n = 0;
      chk({tag, "_accept_busy"}, obs_busy, 1);
      chk({tag, "_accept_flag"}, obs_rf, 0);
      if (drop) begin
         start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      end
      base_addr = AW'($urandom_range(0, 7));
      busy_n = obs_busy ? 1 : 0;
      while (obs_rf !== 1'b1 && n < 40) begin
         tick();
         n++;
         if (obs_busy === 1'b1) busy_n++;
      end
      chk({tag, "_latency"}, n, lat);
      chk({tag, "_busy_cycles"}, busy_n, lat);
      chk({tag, "_reads_left"}, addr_exp.size(), 0);
      chk({tag, "_taps_queued"}, exp_q.size(), KK);
      for (int k = 0; k < KK; k++) begin
         if (exp_q.size() != 0)
            chk_slice($sformatf("%s_tap%0d", tag, k), obs_w[(KK-1-k)*WW +: WW], exp_q.pop_front());
      end
      addr_exp.delete();
      exp_q.delete();
   endtask

   initial begin
      reset = 1'b1;
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      base_addr = '0;
      sel = 0;
      repeat (3) tick();
      chk("rst_rom_en", obs_en, 0);
      chk("rst_rom_addr", obs_addr, 0);
      chk("rst_busy", obs_busy, 0);
      chk("rst_flag", obs_rf, 0);
      chk("rst_state", obs_st, 0);
      chk("rst_weights_nonzero", |obs_w, 0);

      // Auto-start from base 0 on the first edge after reset, latency 1.
      reset = 1'b0;
      expect_load(3'd0);
      run_load("auto", KK + 1, 1'b0);
      chk("u1_no_autostart", {b1.busy, b1.read_flag}, 0);
      chk("u2_no_autostart", {b2.busy, b2.read_flag}, 0);

      // start held through a load, then a back-to-back reload from base 2 out of DONE.
      start0 = 1'b1;
      base_addr = 3'd1;
      expect_load(3'd1);
      run_load("hold1", KK + 1, 1'b0);
      base_addr = 3'd2;
      expect_load(3'd2);
      run_load("hold2", KK + 1, 1'b1);

      // Latency 3, base 4, then wrapping base 6.
      sel = 1;
      start1 = 1'b1;
      base_addr = 3'd4;
      expect_load(3'd4);
      run_load("lat3", KK + 3, 1'b1);
      repeat ($urandom_range(0, 3)) tick();
      chk("lat3_flag_holds", obs_rf, 1);
      start1 = 1'b1;
      base_addr = 3'd6;
      expect_load(3'd6);
      run_load("wrap", KK + 3, 1'b1);

      // Latency 2: a full load, then a reset in the second FETCH cycle of the next one.
      sel = 2;
      start2 = 1'b1;
      base_addr = 3'd3;
      expect_load(3'd3);
      run_load("lat2", KK + 2, 1'b1);
      addr_exp.push_back(3'd0);
      addr_exp.push_back(3'd1);
      start2 = 1'b1;
      base_addr = 3'd0;
      tick();
      chk("abort_accept_busy", obs_busy, 1);
      start2 = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      chk("abort_rom_en", obs_en, 0);
      chk("abort_rom_addr", obs_addr, 0);
      chk("abort_busy", obs_busy, 0);
      chk("abort_flag", obs_rf, 0);
      chk("abort_weights_nonzero", |obs_w, 0);
      reset = 1'b0;
      repeat (6) tick();
      chk("post_abort_flag", obs_rf, 0);
      chk("post_abort_busy", obs_busy, 0);
      chk("post_abort_late_capture", |obs_w, 0);
      chk("post_abort_reads_left", addr_exp.size(), 0);
      addr_exp.delete();
      start2 = 1'b1;
      base_addr = 3'd5;
      expect_load(3'd5);
      run_load("recover", KK + 2, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
